// File: rtl/jtag_ir_dr_chain.sv
// jtag_ir_dr_chain: IR / DR shift chain driven by the TAP controller strobes.
// It holds the instruction register, the decoded instruction, a 1-bit BYPASS
// register and a shared DR shifter used by IDCODE and one USER register.
// Ports:
//   clk, rst_n              TCK-domain clock, synchronous active-low reset
//   tdi, tdo, tdo_en        serial in, serial out and its enable
//   tap_reset               TAP is in TEST_LOGIC_RESET
//   capture/shift/update_ir IR strobes from the TAP
//   capture/shift/update_dr DR strobes from the TAP
//   user_dr_in              value captured into the DR shifter for USER
//   ir_value                currently latched instruction
//   user_dr_out             last completed USER write
//   user_dr_valid/err       one-cycle result pulses after a USER update
module jtag_ir_dr_chain #(
  parameter int unsigned        IR_LEN       = 5,
  parameter int unsigned        DR_W         = 32,
  parameter logic [DR_W-1:0]    IDCODE_VAL   = 32'hDEAD_BEEF,
  parameter logic [IR_LEN-1:0]  IDCODE_INSTR = 5'h01,
  parameter logic [IR_LEN-1:0]  USER_INSTR   = 5'h10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tdi,
  input  logic              tap_reset,
  input  logic              capture_ir,
  input  logic              shift_ir,
  input  logic              update_ir,
  input  logic              capture_dr,
  input  logic              shift_dr,
  input  logic              update_dr,
  input  logic [DR_W-1:0]   user_dr_in,
  output logic              tdo,
  output logic              tdo_en,
  output logic [IR_LEN-1:0] ir_value,
  output logic [DR_W-1:0]   user_dr_out,
  output logic              user_dr_valid,
  output logic              user_dr_err
);

  // Counter must reach DR_W+1 so that an overlong scan stays distinguishable.
  localparam int unsigned CNT_W = $clog2(DR_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DR_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DR_W + 1);
  // IR capture pattern: bit0=1, bit1=0, upper bits 0.
  localparam logic [IR_LEN-1:0] CAPTURE_PAT = IR_LEN'(1);

  logic [IR_LEN-1:0] ir_sr;
  logic [DR_W-1:0]   dr_sr;
  logic              bypass_reg;
  logic [CNT_W-1:0]  bit_cnt;
  logic              sel_idcode;
  logic              sel_user;

  // Instruction decode; anything unrecognised falls back to BYPASS.
  assign sel_idcode = (ir_value == IDCODE_INSTR);
  assign sel_user   = (ir_value == USER_INSTR);

  // Register update with priority tap_reset > capture > shift > update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ir_value      <= IDCODE_INSTR;
      ir_sr         <= CAPTURE_PAT;
      dr_sr         <= '0;
      bypass_reg    <= 1'b0;
      bit_cnt       <= '0;
      user_dr_out   <= '0;
      user_dr_valid <= 1'b0;
      user_dr_err   <= 1'b0;
    end else begin
      user_dr_valid <= 1'b0;
      user_dr_err   <= 1'b0;
      if (tap_reset) begin
        ir_value <= IDCODE_INSTR;
        ir_sr    <= CAPTURE_PAT;
        bit_cnt  <= '0;
      end else if (capture_ir || capture_dr) begin
        if (capture_ir) ir_sr <= CAPTURE_PAT;
        if (capture_dr) begin
          bit_cnt <= '0;
          if (sel_idcode)    dr_sr      <= IDCODE_VAL;
          else if (sel_user) dr_sr      <= user_dr_in;
          else               bypass_reg <= 1'b0;
        end
      end else if (shift_ir || shift_dr) begin
        if (shift_ir) ir_sr <= {tdi, ir_sr[IR_LEN-1:1]};
        if (shift_dr) begin
          if (sel_idcode || sel_user) dr_sr      <= {tdi, dr_sr[DR_W-1:1]};
          else                        bypass_reg <= tdi;
          if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end else if (update_ir || update_dr) begin
        if (update_ir) ir_value <= ir_sr;
        // Only an exact-length USER scan is committed; IDCODE writes are dropped.
        if (update_dr && sel_user) begin
          if (bit_cnt == CNT_FULL) begin
            user_dr_out   <= dr_sr;
            user_dr_valid <= 1'b1;
          end else begin
            user_dr_err   <= 1'b1;
          end
        end
      end
    end
  end

  // Serial output mux, LSB of the active shifter.
  always_comb begin
    tdo = 1'b0;
    if (shift_ir)      tdo = ir_sr[0];
    else if (shift_dr) tdo = (sel_idcode || sel_user) ? dr_sr[0] : bypass_reg;
  end

  assign tdo_en = shift_ir | shift_dr;

endmodule
